// File: rtl/adc_out_fifo.sv
// adc_out_fifo: round-half-up/saturating requantizer feeding a show-ahead FIFO with sticky overflow.
// Define ADC_OUT_SAT_CNT_EN to add the sat_cnt saturation counter output.
module adc_out_fifo #(
    parameter int IN_W  = 35,
    parameter int OUT_W = 16,
    parameter int SHIFT = 19,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      in_vld,
    input  logic signed [IN_W-1:0]    in_dat,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic signed [OUT_W-1:0]   out_dat,
    output logic [$clog2(DEPTH):0]    level,
`ifdef ADC_OUT_SAT_CNT_EN
    output logic [15:0]               sat_cnt,
`endif
    output logic                      ovf,
    input  logic                      ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = IN_W + 1;
    localparam logic signed [SW-1:0] RND  = SW'(1) << (SHIFT - 1);
    localparam logic signed [SW-1:0] MAXV = (SW'(1) << (OUT_W - 1)) - SW'(1);
    localparam logic signed [SW-1:0] MINV = -(SW'(1) << (OUT_W - 1));
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic signed [SW-1:0] sum, q;
    logic sat_hi, sat_lo;
    logic [OUT_W-1:0] res;
    logic r_vld_q;
    logic [OUT_W-1:0] r_dat_q;
    logic [AW:0] wr_q, rd_q, wr_d, rd_d, lvl_d;
    logic [OUT_W-1:0] mem [DEPTH];
    logic [OUT_W-1:0] out_dat_q, out_dat_d;
    logic ovf_q, ovf_d;
    logic full, pop, wr_en, drop;

    always_comb begin
        sum = $signed({in_dat[IN_W-1], in_dat}) + RND;
        q = sum >>> SHIFT;
        sat_hi = q > MAXV;
        sat_lo = q < MINV;
        res = sat_hi ? {1'b0, {(OUT_W-1){1'b1}}} : sat_lo ? {1'b1, {(OUT_W-1){1'b0}}} : q[OUT_W-1:0];
        level = wr_q - rd_q;
        full = level == FULL;
        out_vld = level != '0;
        pop = out_vld && out_rdy;
        wr_en = r_vld_q && (!full || pop);
        drop = r_vld_q && full && !pop;
        wr_d = wr_q + (AW+1)'(wr_en);
        rd_d = rd_q + (AW+1)'(pop);
        lvl_d = wr_d - rd_d;
        // the head register tracks the entry that will be at the read pointer after this edge
        out_dat_d = (wr_en && level == (AW+1)'(pop)) ? r_dat_q :
                    lvl_d != '0 ? mem[rd_d[AW-1:0]] : out_dat_q;
        ovf_d = (drop && en) || (ovf_q && !ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_q[AW-1:0]] <= r_dat_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_q   <= 1'b0;
            r_dat_q   <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            out_dat_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            r_vld_q <= en && in_vld;
            if (en && in_vld)
                r_dat_q <= res;
            wr_q      <= en ? wr_d : '0;
            rd_q      <= en ? rd_d : '0;
            out_dat_q <= en ? out_dat_d : out_dat_q;
            ovf_q     <= ovf_d;
        end
    end

    assign out_dat = out_dat_q;
    assign ovf     = ovf_q;

`ifdef ADC_OUT_SAT_CNT_EN
    logic [15:0] sat_cnt_q;
    always_ff @(posedge clk) begin
        if (rst || ovf_clr)
            sat_cnt_q <= '0;
        else if (en && in_vld && (sat_hi || sat_lo) && sat_cnt_q != 16'hFFFF)
            sat_cnt_q <= sat_cnt_q + 16'd1;
    end
    assign sat_cnt = sat_cnt_q;
`endif
endmodule

// File: tb/tb_adc_out_fifo.sv
// tb_adc_out_fifo: scoreboard bench for adc_out_fifo (default parameters).
module tb_adc_out_fifo;
    logic clk, rst, en, in_vld, out_rdy, ovf_clr, out_vld, ovf;
    logic signed [34:0] in_dat;
    logic signed [15:0] out_dat;
    logic [3:0] level;
`ifdef ADC_OUT_SAT_CNT_EN
    logic [15:0] sat_cnt;
`endif
    int checks = 0;
    int failures = 0;
    longint exp_q[$];

    adc_out_fifo dut (
        .clk(clk), .rst(rst), .en(en), .in_vld(in_vld), .in_dat(in_dat),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .level(level),
`ifdef ADC_OUT_SAT_CNT_EN
        .sat_cnt(sat_cnt),
`endif
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint model(input longint x);
        longint r;
        r = (x + 262144) >>> 19;
        return r > 32767 ? 32767 : r < -32768 ? -32768 : r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input longint x, input bit keep);
        in_dat = x[34:0];
        in_vld = 1'b1;
        if (keep)
            exp_q.push_back(model(x));
        step();
        in_vld = 1'b0;
    endtask

    task automatic drain();
        out_rdy = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++)
            step();
        chk("drain_left", exp_q.size(), 0);
        step();
        chk("drain_level", longint'(level), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && en && out_vld && out_rdy) begin
            if (exp_q.size() == 0)
                chk("spurious_vld", longint'(out_vld), 0);
            else
                chk("out_dat", longint'(out_dat), exp_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    longint rnd_in[4]  = '{262144, -262144, -262145, 786431};
    longint rnd_out[4] = '{1, 0, -1, 1};

    initial begin
        logic [63:0] t;
        logic [34:0] r35;
        rst = 1'b1; en = 1'b1; in_vld = 1'b0; in_dat = '0; out_rdy = 1'b0; ovf_clr = 1'b0;
        repeat (3) step();
        chk("rst_vld", longint'(out_vld), 0);
        chk("rst_dat", longint'(out_dat), 0);
        chk("rst_level", longint'(level), 0);
        chk("rst_ovf", longint'(ovf), 0);
        rst = 1'b0;
        out_rdy = 1'b1;
        step();
        // basic latency
        strobe(524288, 1'b1);
        step();
        chk("lat_vld", longint'(out_vld), 1);
        chk("lat_dat", longint'(out_dat), 1);
        chk("lat_level", longint'(level), 1);
        step();
        chk("lat_level_after_pop", longint'(level), 0);
        // rounding with constant expectations
        for (int i = 0; i < 4; i++) begin
            chk("round_model", model(rnd_in[i]), rnd_out[i]);
            strobe(rnd_in[i], 1'b1);
            step();
            step();
        end
        drain();
        // saturation
        strobe(64'sd17179869183, 1'b1);
`ifdef ADC_OUT_SAT_CNT_EN
        chk("sat_cnt_hi", longint'(sat_cnt), 1);
`endif
        step();
        step();
        chk("sat_hi_dat", longint'(out_dat), 32767);
        strobe(-64'sd17179869184, 1'b1);
`ifdef ADC_OUT_SAT_CNT_EN
        chk("sat_cnt_lo", longint'(sat_cnt), 1);
`endif
        step();
        step();
        chk("sat_lo_dat", longint'(out_dat), -32768);
        drain();
        // random traffic with backpressure
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 6; k++) begin
                out_rdy = $urandom_range(0, 1) != 0;
                t = {$urandom(), $urandom()};
                r35 = t[34:0];
                if (k % 2 == 0)
                    r35 = {{12{r35[22]}}, r35[22:0]};
                strobe(longint'($signed(r35)), 1'b1);
                out_rdy = $urandom_range(0, 1) != 0;
                step();
            end
            drain();
        end
        // fill and overflow
        out_rdy = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            strobe(longint'(k) <<< 19, 1'b1);
            step();
        end
        step();
        chk("fill_level", longint'(level), 8);
        chk("fill_ovf", longint'(ovf), 0);
        strobe(longint'(9) <<< 19, 1'b0);
        step();
        step();
        chk("ovf_level", longint'(level), 8);
        chk("ovf_set", longint'(ovf), 1);
        drain();
        // full with simultaneous push and pop
        out_rdy = 1'b0;
        for (int k = 10; k <= 17; k++) begin
            strobe(longint'(k) <<< 19, 1'b1);
            step();
        end
        step();
        chk("full2_level", longint'(level), 8);
        strobe(longint'(18) <<< 19, 1'b1);
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        chk("pushpop_level", longint'(level), 8);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr_alone", longint'(ovf), 0);
        strobe(longint'(19) <<< 19, 1'b0);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr_vs_set", longint'(ovf), 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr_again", longint'(ovf), 0);
        drain();
        // en low flush with ovf retained
        out_rdy = 1'b0;
        for (int k = 20; k <= 28; k++) begin
            strobe(longint'(k) <<< 19, k != 28);
            step();
        end
        step();
        chk("pre_flush_ovf", longint'(ovf), 1);
        out_rdy = 1'b1;
        repeat (3) step();
        out_rdy = 1'b0;
        chk("pre_flush_level", longint'(level), 5);
        en = 1'b0;
        step();
        en = 1'b1;
        exp_q.delete();
        chk("flush_level", longint'(level), 0);
        chk("flush_vld", longint'(out_vld), 0);
        chk("flush_ovf", longint'(ovf), 1);
        // reset with data buffered and a sample in flight
        for (int k = 30; k <= 32; k++) begin
            strobe(longint'(k) <<< 19, 1'b1);
            step();
        end
        step();
        chk("pre_rst_level", longint'(level), 3);
        strobe(longint'(33) <<< 19, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        chk("mid_rst_vld", longint'(out_vld), 0);
        chk("mid_rst_dat", longint'(out_dat), 0);
        chk("mid_rst_level", longint'(level), 0);
        chk("mid_rst_ovf", longint'(ovf), 0);
        out_rdy = 1'b1;
        repeat (5) step();
        chk("post_rst_level", longint'(level), 0);
        chk("post_rst_vld", longint'(out_vld), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adc_out_fifo.md
Name: adc_out_fifo

Overview:
Output stage of the ADC decimation chain. It consumes the 35-bit signed samples and their single-cycle valid strobe from the second half-band stage. Each sample is requantized to OUT_W bits using round-half-up and saturation, then buffered in a small synchronous FIFO. Samples are presented to the system bus side through a valid/ready handshake, with overflow reporting.

Parameters:
IN_W, 35, input sample width (signed)
OUT_W, 16, output sample width (signed)
SHIFT, 19, arithmetic right-shift applied before saturation; must be 1..IN_W-1
DEPTH, 8, FIFO depth in samples; must be a power of two, 2..64

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
en  input  1  block enable; low flushes the pipeline and FIFO
in_vld  input  1  single-cycle strobe marking a valid in_dat (decimated-rate sample)
in_dat  input  IN_W  signed sample from the half-band stage
out_vld  output  1  FIFO head valid
out_rdy  input  1  consumer ready; a pop occurs when out_vld and out_rdy are both high
out_dat  output  OUT_W  signed FIFO head sample
level  output  $clog2(DEPTH)+1  number of samples currently in the FIFO
ovf  output  1  sticky overflow flag
ovf_clr  input  1  clears ovf

Behaviour:
- Reset (rst=1 at a clk edge): out_vld=0, out_dat=0, level=0, ovf=0, requant stage empty, pointers=0. Reset mid-operation discards all buffered data.
- Stage 1 (requant), loaded at the edge where en&in_vld=1:
  - sum = sign-extended in_dat (IN_W+1 bits) + 2^(SHIFT-1); the extra bit means the rounding add never wraps.
  - q = sum >>> SHIFT (arithmetic).
  - If q > 2^(OUT_W-1)-1, the result is 2^(OUT_W-1)-1. If q < -2^(OUT_W-1), the result is -2^(OUT_W-1). Otherwise the result is q[OUT_W-1:0].
  - Stage valid bit r_vld is set for exactly one cycle per accepted sample.
- Stage 2 (FIFO write): at the edge after stage 1 loads, the result is pushed if r_vld=1.
- Latency: sample strobed at edge E0 is written at E1. If the FIFO was empty, out_vld=1 and out_dat is valid after E1 (2 clk edges).
- FIFO is show-ahead: out_dat always reflects the head entry while out_vld=1. out_dat holds its last value when empty.
- Push and pop in the same cycle:
  - When not full: both take effect and level is unchanged.
  - When full with pop: the push is accepted and level stays at DEPTH.
- Overflow: a push while full with no pop drops the NEW sample, leaves the FIFO contents untouched, and sets ovf.
- ovf clearing: ovf_clr=1 clears ovf at the edge. If ovf_clr and a new overflow occur in the same cycle, ovf stays 1.
- Pointers are log2(DEPTH)+1 bits with a wrap bit. full = (level==DEPTH); empty = (level==0). Wrap-around is seamless.
- en=0 at an edge:
  - r_vld is cleared and the FIFO is flushed (level=0, out_vld=0).
  - in_vld is ignored.
  - ovf is retained.
- en rising: normal operation resumes on the next in_vld.
- in_vld is guaranteed single-cycle and at least 2 cycles apart by the upstream decimator. The block does not rely on this: back-to-back strobes are each accepted.

Optional Feature:
Macro ADC_OUT_SAT_CNT_EN.
- Defined: adds output port sat_cnt (input ... no, output, 16 bits). It increments on every accepted sample whose value saturated in stage 1, and holds at 16'hFFFF. It is cleared by rst, and also by ovf_clr at that edge. If a clear and an increment occur in the same cycle, the clear wins and the result is 0.
- Not defined: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
1. Defaults, out_rdy=1: in_dat=524288 strobed at E0 -> out_vld=1, out_dat=1 after E1; level returns to 0 after the pop edge.
2. Rounding: in_dat=262144 -> 1; in_dat=-262144 -> 0; in_dat=-262145 -> -1; in_dat=786431 -> 1.
3. Saturation: in_dat=2^34-1 -> 32767 (sat_cnt +1 if enabled); in_dat=-2^34 -> -32768 with no saturation count.
4. out_rdy=0, 8 strobes with values 1..8 -> level=8, ovf=0. Then a 9th strobe (value 9) -> level=8, ovf=1. Then out_rdy=1 -> reads 1..8 in order; value 9 never appears.
5. FIFO full, out_rdy=1 and a push in the same cycle -> level stays 8, and the pushed value appears after the 7 remaining entries. Assert ovf_clr while an overflow occurs in the same cycle -> ovf stays 1; ovf_clr alone -> ovf=0.
6. With level=5, drive en=0 for 1 cycle -> level=0, out_vld=0, ovf retained. Separately, rst=1 with level=3 and r_vld=1 -> all outputs at reset values at the next edge, and no stale sample is emitted afterwards.
